// File: rtl/rsenc_lfsr.sv
// Systematic RS(255,223) encoder over GF(2^8) using the 0x187 field polynomial.
// Message symbols pass straight through while a 32-stage LFSR divides by g(x); the 32 parity symbols follow.
module rsenc_lfsr #(
    parameter int unsigned K = 223
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       enable,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_parity,
    output logic       out_last
);

    localparam int unsigned NPAR    = 32;
    localparam int unsigned CNT_MAX = (K > NPAR) ? K : NPAR;
    localparam int unsigned CNT_W   = ($clog2(CNT_MAX) < 6) ? 6 : $clog2(CNT_MAX);

    // GF(2^8) multiply: shift-and-add, reducing by x^8+x^7+x^2+x+1 (low byte 0x87)
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h87 : 8'h00);
        end
        return acc;
    endfunction

    // g(x) = prod_{i=0..31} (x + alpha^i); returns g0..g31 (the monic x^32 term is implied)
    function automatic logic [NPAR*8-1:0] gen_poly();
        logic [(NPAR+1)*8-1:0] g;
        logic [7:0]            root;
        g       = '0;
        g[7:0]  = 8'h01;
        root    = 8'h01;
        for (int i = 0; i < int'(NPAR); i++) begin
            for (int j = NPAR; j >= 1; j--) begin
                g[j*8 +: 8] = g[(j-1)*8 +: 8] ^ gf_mul(root, g[j*8 +: 8]);
            end
            g[7:0] = gf_mul(root, g[7:0]);
            root   = gf_mul(root, 8'h02);
        end
        return g[NPAR*8-1:0];
    endfunction

    localparam logic [NPAR*8-1:0] GEN = gen_poly();

    typedef enum logic {
        ST_MSG = 1'b0,
        ST_PAR = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       r_q [NPAR];
    logic [7:0]       r_d [NPAR];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_parity_q, out_parity_d;
    logic             out_last_q, out_last_d;

    logic       load_ok;
    logic       in_fire;
    logic       par_fire;
    logic       msg_last;
    logic       par_last;
    logic [7:0] fb;

    assign load_ok  = !out_valid_q || out_ready;
    assign in_ready = enable && (state_q == ST_MSG) && load_ok;
    assign in_fire  = in_valid && in_ready;
    assign par_fire = enable && (state_q == ST_PAR) && load_ok;
    assign msg_last = (cnt_q == CNT_W'(K - 1));
    assign par_last = (cnt_q == CNT_W'(NPAR - 1));
    assign fb       = in_data ^ r_q[NPAR-1];

    // State register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state_q <= ST_MSG;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!enable)                 state_d = ST_MSG;
        else if (in_fire && msg_last) state_d = ST_PAR;
        else if (par_fire && par_last) state_d = ST_MSG;
    end

    // LFSR, symbol counter and output register next values
    always_comb begin
        r_d          = r_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_parity_d = out_parity_q;
        out_last_d   = out_last_q;
        if (!enable) begin
            for (int i = 0; i < int'(NPAR); i++) r_d[i] = 8'h00;
            cnt_d        = '0;
            out_valid_d  = 1'b0;
            out_data_d   = 8'h00;
            out_parity_d = 1'b0;
            out_last_d   = 1'b0;
        end else if (in_fire) begin
            r_d[0] = gf_mul(GEN[7:0], fb);
            for (int i = 1; i < int'(NPAR); i++) r_d[i] = r_q[i-1] ^ gf_mul(GEN[i*8 +: 8], fb);
            cnt_d        = msg_last ? '0 : cnt_q + CNT_W'(1);
            out_valid_d  = 1'b1;
            out_data_d   = in_data;
            out_parity_d = 1'b0;
            out_last_d   = 1'b0;
        end else if (par_fire) begin
            r_d[0] = 8'h00;
            for (int i = 1; i < int'(NPAR); i++) r_d[i] = r_q[i-1];
            cnt_d        = par_last ? '0 : cnt_q + CNT_W'(1);
            out_valid_d  = 1'b1;
            out_data_d   = r_q[NPAR-1];
            out_parity_d = 1'b1;
            out_last_d   = par_last;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < int'(NPAR); i++) r_q[i] <= 8'h00;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'h00;
            out_parity_q <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            r_q          <= r_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_parity_q <= out_parity_d;
            out_last_q   <= out_last_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_parity = out_parity_q;
    assign out_last   = out_last_q;

endmodule

// File: tb/tb_rsenc_lfsr.sv
// Bench for rsenc_lfsr: a K=223 and a K=1 instance checked against a log/antilog
// GF model, polynomial long division and syndrome evaluation.
module tb_rsenc_lfsr;

    localparam int unsigned KA = 223;
    localparam int unsigned KB = 1;

    logic       clk = 1'b0;
    logic       clrn;
    logic       en_a, en_b;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       sel;

    logic       rdy_a, ov_a, op_a, ol_a;
    logic [7:0] od_a;
    logic       rdy_b, ov_b, op_b, ol_b;
    logic [7:0] od_b;

    wire        i_ready = sel ? rdy_b : rdy_a;
    wire        o_valid = sel ? ov_b  : ov_a;
    wire [7:0]  o_data  = sel ? od_b  : od_a;
    wire        o_par   = sel ? op_b  : op_a;
    wire        o_last  = sel ? ol_b  : ol_a;

    always #5 clk = ~clk;

    rsenc_lfsr #(.K(KA)) u_a (
        .clk(clk), .clrn(clrn), .enable(en_a),
        .in_valid(in_valid), .in_ready(rdy_a), .in_data(in_data),
        .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a),
        .out_parity(op_a), .out_last(ol_a)
    );

    rsenc_lfsr #(.K(KB)) u_b (
        .clk(clk), .clrn(clrn), .enable(en_b),
        .in_valid(in_valid), .in_ready(rdy_b), .in_data(in_data),
        .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b),
        .out_parity(op_b), .out_last(ol_b)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         gexp [0:509];
    int         glog [0:255];
    logic [7:0] gdesc [0:32];
    logic [7:0] msg [0:222];
    logic [7:0] ref_cw [0:254];
    logic [7:0] got_d [0:255];
    logic       got_p [0:255];
    logic       got_l [0:255];

    // GF model built from powers of alpha
    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return 8'(gexp[glog[a] + glog[b]]);
    endfunction

    task automatic build_model();
        int         e;
        logic [7:0] asc [0:32];
        e = 1;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = e;
            glog[e] = i;
            e = e << 1;
            if ((e & 256) != 0) e = e ^ 32'h187;
        end
        for (int i = 255; i < 510; i++) gexp[i] = gexp[i-255];
        for (int j = 0; j <= 32; j++) asc[j] = 8'h00;
        asc[0] = 8'h01;
        for (int i = 0; i < 32; i++) begin
            for (int j = i + 1; j >= 1; j--) asc[j] = asc[j-1] ^ mul(8'(gexp[i]), asc[j]);
            asc[0] = mul(8'(gexp[i]), asc[0]);
        end
        for (int j = 0; j <= 32; j++) gdesc[j] = asc[32-j];
    endtask

    // Reference codeword: message followed by remainder of m(x)*x^32 / g(x)
    task automatic model_encode(input int k);
        logic [7:0] w [0:254];
        logic [7:0] c;
        for (int i = 0; i < k + 32; i++) w[i] = (i < k) ? msg[i] : 8'h00;
        for (int i = 0; i < k; i++) begin
            c = w[i];
            for (int j = 1; j <= 32; j++) w[i+j] = w[i+j] ^ mul(c, gdesc[j]);
        end
        for (int i = 0; i < k; i++) ref_cw[i] = msg[i];
        for (int j = 0; j < 32; j++) ref_cw[k+j] = w[k+j];
    endtask

    function automatic int bad_syndromes(input int n);
        int         bad;
        logic [7:0] s;
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            s = 8'h00;
            for (int j = 0; j < n; j++) s = mul(s, 8'(gexp[i])) ^ got_d[j];
            if (s != 8'h00) bad++;
        end
        return bad;
    endfunction

    function automatic int cw_mismatch(input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) if (got_d[i] !== ref_cw[i]) bad++;
        return bad;
    endfunction

    function automatic int flag_errors(input int k, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (got_p[i] !== (i >= k)) bad++;
            if (got_l[i] !== (i == n - 1)) bad++;
        end
        return bad;
    endfunction

    // Drive one message and record output transfers; returns at a negedge
    task automatic drive(input int n, input int pv, input int pr, input int abort_after,
                         output int n_out, output int stall_err, output int rdy_low, output bit done);
        int         idx, cyc;
        bit         prev_stall;
        logic [7:0] prev_data;
        idx = 0; n_out = 0; stall_err = 0; rdy_low = 0; done = 1'b0; cyc = 0;
        prev_stall = 1'b0; prev_data = 8'h00;
        while (!done && cyc < 6000) begin
            @(posedge clk);
            #1;
            in_valid  = (idx < n) && ($urandom_range(99) < pv);
            in_data   = in_valid ? msg[idx] : 8'($urandom);
            out_ready = ($urandom_range(99) < pr);
            @(negedge clk);
            if (prev_stall && (!o_valid || o_data !== prev_data)) stall_err++;
            prev_stall = o_valid && !out_ready;
            prev_data  = o_data;
            if (!i_ready) rdy_low++;
            if (in_valid && i_ready) idx++;
            if (o_valid && out_ready && n_out < 256) begin
                got_d[n_out] = o_data;
                got_p[n_out] = o_par;
                got_l[n_out] = o_last;
                n_out++;
                if (o_last) done = 1'b1;
                if (abort_after != 0 && n_out == abort_after) done = 1'b1;
            end
            cyc++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        clrn = 1'b0; en_a = 1'b0; en_b = 1'b0; sel = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        #12;
        n_checks++; if (ov_a !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid got %b want 0", ov_a); end
        n_checks++; if (od_a !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h want 00", od_a); end
        n_checks++; if (op_a !== 1'b0)  begin n_fail++; $display("FAIL reset_out_parity got %b want 0", op_a); end
        n_checks++; if (ol_a !== 1'b0)  begin n_fail++; $display("FAIL reset_out_last got %b want 0", ol_a); end
        n_checks++; if (rdy_a !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", rdy_a); end
        clrn = 1'b1;
        @(negedge clk);
        en_a = 1'b1;
        #1;
        n_checks++; if (rdy_a !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready got %b want 1", rdy_a); end
    endtask

    task automatic test_all_zero();
        int n_out, st, rl, bad;
        bit done;
        for (int i = 0; i < 223; i++) msg[i] = 8'h00;
        drive(223, 100, 100, 0, n_out, st, rl, done);
        n_checks++; if (!done || n_out !== 255) begin n_fail++; $display("FAIL zero_count got %0d done %0d want 255", n_out, done); end
        bad = 0;
        for (int i = 0; i < n_out; i++) if (got_d[i] !== 8'h00) bad++;
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL zero_data got %0d nonzero symbols want 0", bad); end
        n_checks++; if (flag_errors(223, n_out) !== 0) begin n_fail++; $display("FAIL zero_flags got %0d flag errors want 0", flag_errors(223, n_out)); end
        n_checks++; if (rl !== 32) begin n_fail++; $display("FAIL zero_in_ready_low got %0d cycles want 32", rl); end
    endtask

    task automatic test_impulse();
        int         n_out, st, rl, bad;
        bit         done;
        logic [7:0] sum;
        for (int i = 0; i < 223; i++) msg[i] = 8'h00;
        msg[222] = 8'h01;
        drive(223, 100, 100, 0, n_out, st, rl, done);
        n_checks++; if (!done || n_out !== 255) begin n_fail++; $display("FAIL impulse_count got %0d want 255", n_out); end
        bad = 0;
        for (int j = 0; j < 32; j++) if (got_d[223+j] !== gdesc[j+1]) bad++;
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL impulse_gen got %0d mismatches want 0", bad); end
        n_checks++; if (got_d[254] !== 8'(gexp[241])) begin n_fail++; $display("FAIL impulse_g0 got %h want %h", got_d[254], 8'(gexp[241])); end
        sum = 8'h00;
        for (int i = 0; i < 32; i++) sum = sum ^ 8'(gexp[i]);
        n_checks++; if (got_d[223] !== sum) begin n_fail++; $display("FAIL impulse_g31 got %h want %h", got_d[223], sum); end
    endtask

    task automatic test_random();
        int n_out, st, rl, bad;
        bit done;
        for (int c = 0; c < 100; c++) begin
            for (int i = 0; i < 223; i++) msg[i] = 8'($urandom);
            model_encode(223);
            drive(223, 100, 100, 0, n_out, st, rl, done);
            n_checks++; if (!done || n_out !== 255) begin n_fail++; $display("FAIL rand_count cw %0d got %0d want 255", c, n_out); end
            bad = cw_mismatch(255);
            n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rand_codeword cw %0d got %0d mismatches want 0", c, bad); end
            bad = bad_syndromes(255);
            n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rand_syndrome cw %0d got %0d nonzero want 0", c, bad); end
        end
    endtask

    task automatic test_throttle();
        int n_out, st, rl, bad;
        bit done;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 223; i++) msg[i] = 8'($urandom);
            model_encode(223);
            drive(223, 50, 50, 0, n_out, st, rl, done);
            n_checks++; if (!done || n_out !== 255) begin n_fail++; $display("FAIL thr_count cw %0d got %0d want 255", c, n_out); end
            bad = cw_mismatch(255);
            n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL thr_codeword cw %0d got %0d mismatches want 0", c, bad); end
            n_checks++; if (st !== 0) begin n_fail++; $display("FAIL thr_stall cw %0d got %0d unstable stalls want 0", c, st); end
            bad = flag_errors(223, n_out);
            n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL thr_flags cw %0d got %0d want 0", c, bad); end
        end
    endtask

    task automatic test_reset_mid();
        int n_out, st, rl, bad;
        bit done;
        for (int i = 0; i < 223; i++) msg[i] = 8'($urandom);
        drive(223, 100, 100, 100, n_out, st, rl, done);
        out_ready = 1'b0;
        #1 clrn = 1'b0;
        #1;
        n_checks++; if (ov_a !== 1'b0 || od_a !== 8'h00) begin n_fail++; $display("FAIL clrn_mid got valid %b data %h want 0 00", ov_a, od_a); end
        n_checks++; if (op_a !== 1'b0 || ol_a !== 1'b0) begin n_fail++; $display("FAIL clrn_mid_flags got %b%b want 00", op_a, ol_a); end
        #1 clrn = 1'b1;
        drive(223, 100, 100, 228, n_out, st, rl, done);
        en_a = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (ov_a !== 1'b0 || rdy_a !== 1'b0 || op_a !== 1'b0) begin n_fail++; $display("FAIL enable_low got valid %b ready %b parity %b want 000", ov_a, rdy_a, op_a); end
        en_a = 1'b1;
        for (int i = 0; i < 223; i++) msg[i] = 8'($urandom);
        model_encode(223);
        drive(223, 100, 100, 0, n_out, st, rl, done);
        n_checks++; if (!done || n_out !== 255) begin n_fail++; $display("FAIL restart_count got %0d want 255", n_out); end
        bad = cw_mismatch(255);
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL restart_codeword got %0d mismatches want 0", bad); end
    endtask

    task automatic test_k1();
        int n_out, st, rl, bad;
        bit done;
        en_a = 1'b0;
        en_b = 1'b1;
        sel  = 1'b1;
        msg[0] = 8'h05;
        drive(1, 100, 100, 0, n_out, st, rl, done);
        n_checks++; if (!done || n_out !== 33) begin n_fail++; $display("FAIL k1_count got %0d want 33", n_out); end
        n_checks++; if (got_d[0] !== 8'h05) begin n_fail++; $display("FAIL k1_msg got %h want 05", got_d[0]); end
        bad = 0;
        for (int j = 0; j < 32; j++) if (got_d[1+j] !== mul(8'h05, gdesc[j+1])) bad++;
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL k1_parity got %0d mismatches want 0", bad); end
        bad = flag_errors(1, n_out);
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL k1_flags got %0d want 0", bad); end
        for (int c = 0; c < 2; c++) begin
            msg[0] = 8'($urandom);
            model_encode(1);
            drive(1, 70, 70, 0, n_out, st, rl, done);
            n_checks++; if (!done || n_out !== 33) begin n_fail++; $display("FAIL k1_next_count got %0d want 33", n_out); end
            bad = cw_mismatch(33);
            n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL k1_next_codeword got %0d mismatches want 0", bad); end
            bad = bad_syndromes(33);
            n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL k1_next_syndrome got %0d nonzero want 0", bad); end
        end
    endtask

    initial begin
        build_model();
        test_reset();
        test_all_zero();
        test_impulse();
        test_random();
        test_throttle();
        test_reset_mid();
        test_k1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
